// File: rtl/ram_nxm_if.sv
// rtl/ram_nxm_if.sv - access/wipe bundle between a storage client and ram_nxm
//
// Purpose : groups the request, response and wipe signals of one ram_nxm
//           port so client and RAM connect through a single interface.
// Signals :
//   enable  client->ram  request an access this cycle
//   rw      client->ram  1 = write, 0 = read
//   address client->ram  word address (AW bits)
//   din     client->ram  write data (WIDTH bits)
//   wipe    client->ram  request a full-array zero sweep
//   dout    ram->client  registered read data (WIDTH bits)
//   valid   ram->client  one-cycle strobe, dout was updated by a read
//   busy    ram->client  zero sweep in progress
interface ram_nxm_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) ();
  localparam int AW = $clog2(DEPTH);

  logic             enable;
  logic             rw;
  logic [AW-1:0]    address;
  logic [WIDTH-1:0] din;
  logic             wipe;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             busy;

  modport master (
    output enable, rw, address, din, wipe,
    input  dout, valid, busy
  );

  modport slave (
    input  enable, rw, address, din, wipe,
    output dout, valid, busy
  );
endinterface

// File: rtl/ram_nxm.sv
// rtl/ram_nxm.sv - parametrised single-port synchronous RAM with self-timed wipe
//
// Purpose : DEPTH x WIDTH storage behind one address/rw port. Reads are
//           registered with a one-cycle valid strobe; a wipe request runs a
//           DEPTH-cycle sweep that zeroes every word while busy is high.
// Ports   :
//   clock  in   rising-edge clock for all state
//   clear  in   asynchronous active-low reset (array, outputs, FSM, counter)
//   bus    slave modport of ram_nxm_if (enable/rw/address/din/wipe in,
//               dout/valid/busy out)
module ram_nxm #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     clear,
  ram_nxm_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  // One bit wider than the address so DEPTH itself is representable.
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WIPE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  logic             w_in_range;
  logic             w_sweep_last;
  logic             w_busy;
  logic             w_wipe_start;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;
  logic [WIDTH-1:0] w_rd_data;

  // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
  assign w_in_range   = ({1'b0, bus.address} < DEPTH_W);
  assign w_sweep_last = (r_cnt == LAST_IDX);

  // Out-of-range reads return zero instead of indexing past the array.
  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      w_rd_data = r_mem[bus.address];
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.wipe)    w_next_state = S_WIPE;
      S_WIPE:  if (w_sweep_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs. A wipe request outranks any access issued in the same cycle.
  always_comb begin
    w_busy       = 1'b0;
    w_wipe_start = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wipe_start = bus.wipe;
        w_wr_en      = !bus.wipe && bus.enable && bus.rw;
        w_rd_en      = !bus.wipe && bus.enable && !bus.rw;
      end
      S_WIPE: begin
        w_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Single write port shared by client writes and the sweep.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.address;
    w_mem_wdata = bus.din;
    if (r_state == S_WIPE) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt;
      w_mem_wdata = '0;
    end else if (w_wr_en && w_in_range) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Sweep counter stops at DEPTH-1 and returns to zero with the FSM.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt <= '0;
    end else if (r_state == S_WIPE) begin
      r_cnt <= w_sweep_last ? '0 : r_cnt + 1'b1;
    end else if (w_wipe_start) begin
      r_cnt <= '0;
    end
  end

  // dout only moves on a read, a wipe start or reset; it holds otherwise.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (w_busy || w_wipe_start) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (w_rd_en) begin
      r_dout  <= w_rd_data;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.dout  = r_dout;
  assign bus.valid = r_valid;
  assign bus.busy  = w_busy;

endmodule

// File: doc/ram_nxm.md
Name: ram_nxm

Overview:
- Parametrised single-port synchronous RAM. It is the successor to the fixed 1-word x 4-bit latch RAM.
- Stores DEPTH words of WIDTH bits behind one address/rw interface, with registered read data and a one-cycle valid strobe.
- Adds a self-timed wipe sequencer that zeroes the whole array while signalling busy.
- Used as the general storage block in guide datapaths, replacing hand-instantiated flip-flop arrays.

Parameters:
- WIDTH, 4, bits per word (>=1).
- DEPTH, 4, number of words (>=2, need not be a power of two).
- AW, $clog2(DEPTH), address width. Derived; not overridden by users.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- clear  input  1  asynchronous, active-low reset.
- enable  input  1  request an access this cycle.
- rw  input  1  1 = write, 0 = read (same sense as the existing RAM).
- address  input  AW  word address.
- din  input  WIDTH  write data.
- dout  output  WIDTH  registered read data.
- valid  output  1  one-cycle strobe: dout updated by a read.
- wipe  input  1  request a full-array zero sweep.
- busy  output  1  wipe sweep in progress.

Behaviour:
- Reset: clear=0 acts immediately, independent of clock.
  - All DEPTH words <= 0, dout=0, valid=0, busy=0, sweep counter=0, FSM=IDLE.
  - Reset asserted mid-sweep aborts the sweep. The array still ends all-zero because reset clears it.
- FSM states: IDLE, WIPE.
- IDLE, rising edge, in priority order:
  - wipe=1: go to WIPE, busy=1 from the next cycle, counter=0, dout<=0, valid<=0. Any same-cycle enable is dropped with no write and no read.
  - enable=1, rw=1: mem[address]<=din. valid<=0.
  - enable=1, rw=0: dout<=mem[address], valid<=1. Latency is exactly 1 cycle: the request at edge N gives data and valid=1 after edge N, for one cycle.
  - enable=0: valid<=0, dout holds.
- WIPE, each rising edge:
  - mem[counter]<=0, then counter<=counter+1.
  - At counter==DEPTH-1, write word DEPTH-1, then IDLE, counter<=0. busy drops on that edge.
  - The sweep takes exactly DEPTH cycles; busy is high for DEPTH cycles.
  - enable, rw, address, din and wipe are ignored; valid stays 0, dout stays 0.
- Out-of-range address (address >= DEPTH, only possible when DEPTH is not a power of two):
  - Write is discarded with no array change.
  - Read returns dout=0 with valid=1.
- Back-to-back access: one access per cycle, no bubbles.
  - Read after write to the same address on the next cycle returns the new data.
  - dout always reflects array contents at the read edge; there is no forwarding within a cycle, since a single port allows only one op per cycle.
- dout holds its last read value through writes and idle cycles. It changes only on a read, a wipe start, or reset.
- Counter width is AW bits, with no wrap beyond DEPTH-1.
- Array contents are retained indefinitely without clock activity.

Test Plan:
- Reset check (WIDTH=4, DEPTH=4): hold clear=0, then release, then read all 4 addresses -> each dout=4'h0 with valid=1 exactly 1 cycle after each request.
- Write/read (WIDTH=8, DEPTH=8): write addr i with 8'hA0+i for i=0..7 back-to-back, then read back-to-back -> dout=8'hA0..8'hA7 in order, valid high for 8 consecutive cycles, then low.
- Wipe (WIDTH=8, DEPTH=8):
  - Fill with 8'hFF, then pulse wipe -> busy=1 for exactly 8 cycles, dout=0.
  - Reads issued during busy give valid=0.
  - After busy falls, all reads return 8'h00.
- Simultaneous wipe and write in IDLE (addr 3, din 8'h5A) -> write dropped, sweep runs; after busy falls, addr 3 reads 8'h00.
- Non-power-of-two (WIDTH=4, DEPTH=5): write 4'h9 to addr 6 -> no effect. Read addr 6 -> dout=0, valid=1. Wipe -> busy for exactly 5 cycles.
- Async reset mid-sweep: pull clear low at sweep cycle 3 between clock edges -> busy, valid, dout go 0 immediately. After release, FSM is IDLE and all words read 0.
